sample_iter_ctrl: RTL and testbench

//  Sequences the sample test datapath. Accepts one triangle plus its bounding box from the bbox stage.

---
 rtl/sample_iter_ctrl_if.sv | 31 +++
 rtl/sample_iter_ctrl.sv | 132 +++++++++++++
 tb/tb_sample_iter_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_iter_ctrl_if.sv
// Triangle/box handoff from bbox plus sample-chunk bus to sampletest.
// slave = the iterator, master = the surrounding pipeline.
interface sample_iter_ctrl_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
);
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U;
  logic [1:0][1:0][SIGFIG-1:0]            box_R13S;
  logic [SIGFIG-1:0]                      step_R13U;
  logic                                   validTri_R13H;
  logic                                   halt_R13H;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
  logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
  logic [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_R14S;
  logic [SAMPS-1:0]                       validSamp_R14H;
  logic                                   halt_R14H;

  modport slave (
    input  tri_R13S, color_R13U, box_R13S, step_R13U, validTri_R13H, halt_R14H,
    output halt_R13H, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );

  modport master (
    output tri_R13S, color_R13U, box_R13S, step_R13U, validTri_R13H, halt_R14H,
    input  halt_R13H, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );
endinterface

// File: rtl/sample_iter_ctrl.sv
// Raster-walks a triangle's bbox, SAMPS x-adjacent samples per cycle; first chunk 1 cycle after accept.
// halt_R14H freezes everything; halt_R13H stalls bbox. ITER_BACK2BACK_EN: accept next tri on last chunk.
module sample_iter_ctrl #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
) (
  input logic               clk,
  input logic               rst,
  sample_iter_ctrl_if.slave bus
);
  typedef enum logic {WAIT, TEST} state_t;

  state_t                                 state_q, state_d;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d, tri_out_q, tri_out_d;
  logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d, color_out_q, color_out_d;
  logic [SIGFIG-1:0]                      llx_q, llx_d, urx_q, urx_d, ury_q, ury_d;
  logic [SIGFIG-1:0]                      step_q, step_d, curx_q, curx_d, cury_q, cury_d;
  logic [1:0][SAMPS-1:0][SIGFIG-1:0]      samp_q, samp_d;
  logic [SAMPS-1:0]                       vld_q, vld_d;

  logic [SIGFIG-1:0] nx, ny, lane_x;
  logic              row_end, last_chunk, accept;

  assign nx         = curx_q + SIGFIG'(SAMPS) * step_q;
  assign ny         = cury_q + step_q;
  assign row_end    = $signed(nx) > $signed(urx_q);
  assign last_chunk = (state_q == TEST) && row_end && ($signed(ny) > $signed(ury_q));

`ifdef ITER_BACK2BACK_EN
  assign bus.halt_R13H = bus.halt_R14H | ((state_q == TEST) & ~last_chunk);
`else
  assign bus.halt_R13H = bus.halt_R14H | (state_q == TEST);
`endif
  // halt_R13H already folds in state and downstream stall, so it doubles as the accept gate.
  assign accept = bus.validTri_R13H & ~bus.halt_R13H;

  always_comb begin
    state_d     = state_q;
    tri_d       = tri_q;
    color_d     = color_q;
    tri_out_d   = tri_out_q;
    color_out_d = color_out_q;
    llx_d       = llx_q;
    urx_d       = urx_q;
    ury_d       = ury_q;
    step_d      = step_q;
    curx_d      = curx_q;
    cury_d      = cury_q;
    samp_d      = samp_q;
    vld_d       = vld_q;
    lane_x      = '0;
    if (!bus.halt_R14H) begin
      vld_d = '0;
      if (state_q == TEST) begin
        for (int i = 0; i < SAMPS; i++) begin
          lane_x       = curx_q + SIGFIG'(i) * step_q;
          samp_d[0][i] = lane_x;
          samp_d[1][i] = cury_q;
          vld_d[i]     = $signed(lane_x) <= $signed(urx_q);
        end
        tri_out_d   = tri_q;
        color_out_d = color_q;
        if (!row_end) begin
          curx_d = nx;
        end else begin
          curx_d = llx_q;
          cury_d = ny;
        end
        if (last_chunk) state_d = WAIT;
      end
      if (accept) begin
        tri_d   = bus.tri_R13S;
        color_d = bus.color_R13U;
        llx_d   = bus.box_R13S[0][0];
        urx_d   = bus.box_R13S[1][0];
        ury_d   = bus.box_R13S[1][1];
        step_d  = bus.step_R13U;
        curx_d  = bus.box_R13S[0][0];
        cury_d  = bus.box_R13S[0][1];
        state_d = TEST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT;
      tri_q       <= '0;
      color_q     <= '0;
      tri_out_q   <= '0;
      color_out_q <= '0;
      llx_q       <= '0;
      urx_q       <= '0;
      ury_q       <= '0;
      step_q      <= '0;
      curx_q      <= '0;
      cury_q      <= '0;
      samp_q      <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      tri_q       <= tri_d;
      color_q     <= color_d;
      tri_out_q   <= tri_out_d;
      color_out_q <= color_out_d;
      llx_q       <= llx_d;
      urx_q       <= urx_d;
      ury_q       <= ury_d;
      step_q      <= step_d;
      curx_q      <= curx_d;
      cury_q      <= cury_d;
      samp_q      <= samp_d;
      vld_q       <= vld_d;
    end
  end

  assign bus.tri_R14S       = tri_out_q;
  assign bus.color_R14U     = color_out_q;
  assign bus.sample_R14S    = samp_q;
  assign bus.validSamp_R14H = vld_q;

  // Lanes walk at step granularity, so the step must be a nonzero power of two inside the word.
  a_legal_input: assert property (@(posedge clk) disable iff (rst)
    accept |-> ((RADIX < SIGFIG) && (bus.step_R13U != '0) &&
                ((bus.step_R13U & (bus.step_R13U - 1'b1)) == '0) &&
                ($signed(bus.box_R13S[0][0]) <= $signed(bus.box_R13S[1][0])) &&
                ($signed(bus.box_R13S[0][1]) <= $signed(bus.box_R13S[1][1]))));
endmodule

// File: tb/tb_sample_iter_ctrl.sv
// Bench for sample_iter_ctrl: box table, directed corner sequences, randomized run vs a raster model.
module tb_sample_iter_ctrl;
  localparam int SIGFIG = 24;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int SAMPS  = 4;

  typedef struct packed {
    logic [SAMPS-1:0][SIGFIG-1:0]           x;
    logic [SIGFIG-1:0]                      y;
    logic [SAMPS-1:0]                       v;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] t;
    logic [COLORS-1:0][SIGFIG-1:0]          c;
  } chunk_t;

  typedef struct {
    int         llx, lly, urx, ury;
    int         cycles;
    logic [3:0] first, last;
  } vec_t;

  logic clk;
  logic rst;
  sample_iter_ctrl_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS), .SAMPS(SAMPS)) bus ();

  sample_iter_ctrl #(.SIGFIG(SIGFIG), .RADIX(10), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS), .SAMPS(SAMPS))
    dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     failures = 0;
  chunk_t q[$];
  chunk_t exp_c;
  bit     exp_full;
  bit     started;
  int     p_llx, p_lly, p_urx, p_ury, p_step;
  vec_t   vecs[6];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: enumerate the box row by row, SAMPS lanes per chunk, from the raster rules.
  task automatic push_tri();
    for (int y = p_lly; y <= p_ury; y += p_step) begin
      for (int x = p_llx; x <= p_urx; x += SAMPS * p_step) begin
        chunk_t c;
        c = '0;
        for (int i = 0; i < SAMPS; i++) begin
          c.x[i] = SIGFIG'(x + i * p_step);
          c.v[i] = (x + i * p_step) <= p_urx;
        end
        c.y = SIGFIG'(y);
        c.t = bus.tri_R13S;
        c.c = bus.color_R13U;
        q.push_back(c);
      end
    end
  endtask

  task automatic present(input int llx, input int lly, input int urx, input int ury, input int step);
    p_llx = llx; p_lly = lly; p_urx = urx; p_ury = ury; p_step = step;
    bus.box_R13S[0][0] = SIGFIG'(llx);
    bus.box_R13S[0][1] = SIGFIG'(lly);
    bus.box_R13S[1][0] = SIGFIG'(urx);
    bus.box_R13S[1][1] = SIGFIG'(ury);
    bus.step_R13U      = SIGFIG'(step);
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++) bus.tri_R13S[v][a] = SIGFIG'($urandom);
    for (int k = 0; k < COLORS; k++) bus.color_R13U[k] = SIGFIG'($urandom);
  endtask

  task automatic tick(output bit acc);
    bit r, h;
    int n;
    logic [SAMPS-1:0][SIGFIG-1:0] ys;
    #1;
    n = q.size();
    if (started) begin
`ifdef ITER_BACK2BACK_EN
      chk("halt_R13H", bus.halt_R13H, bus.halt_R14H | (n > 1));
`else
      chk("halt_R13H", bus.halt_R13H, bus.halt_R14H | (n > 0));
`endif
    end
    acc = bus.validTri_R13H && !bus.halt_R13H && !rst;
    r = rst;
    h = bus.halt_R14H;
    @(posedge clk);
    started = 1'b1;
    if (r) begin
      exp_c = '0; exp_full = 1'b1; q.delete();
    end else if (!h) begin
      if (q.size() > 0) begin
        exp_c = q.pop_front(); exp_full = 1'b1;
      end else begin
        exp_c.v = '0; exp_full = 1'b0;
      end
    end
    if (acc) push_tri();
    #1;
    chk("validSamp", bus.validSamp_R14H, exp_c.v);
    if (exp_full) begin
      for (int i = 0; i < SAMPS; i++) ys[i] = exp_c.y;
      chk("sample_x", bus.sample_R14S[0], exp_c.x);
      chk("sample_y", bus.sample_R14S[1], ys);
      chk("tri_R14S", bus.tri_R14S, exp_c.t);
      chk("color_R14U", bus.color_R14U, exp_c.c);
    end
  endtask

  bit         acc;
  int         n;
  logic [3:0] first, last, pat;
  bit         pend;

  initial begin
    vecs[0] = '{0, 0, 3072, 1024, 2, 4'b1111, 4'b1111};
    vecs[1] = '{0, 0, 1024, 0, 1, 4'b0011, 4'b0011};
    vecs[2] = '{0, 0, 0, 0, 1, 4'b0001, 4'b0001};
    vecs[3] = '{0, 0, 4096, 0, 2, 4'b1111, 4'b0001};
    vecs[4] = '{-2048, -1024, 2048, 1024, 6, 4'b1111, 4'b0001};
    vecs[5] = '{1024, 2048, 3072, 2048, 1, 4'b0111, 4'b0111};

    rst = 1'b1;
    bus.validTri_R13H = 1'b0;
    bus.halt_R14H = 1'b0;
    present(0, 0, 0, 0, 1024);
    started = 1'b0;
    exp_c = '0;
    exp_full = 1'b1;

    // Reset
    tick(acc); tick(acc);
    rst = 1'b0;
    #1;
    chk("rst_valid", bus.validSamp_R14H, 0);
    chk("rst_samples", bus.sample_R14S, 0);
    chk("rst_tri", bus.tri_R14S, 0);
    chk("rst_color", bus.color_R14U, 0);
    chk("rst_halt13", bus.halt_R13H, 0);

    // Box table
    for (int e = 0; e < 6; e++) begin
      present(vecs[e].llx, vecs[e].lly, vecs[e].urx, vecs[e].ury, 1024);
      bus.validTri_R13H = 1'b1;
      tick(acc);
      chk("vec_accept", acc, 1);
      bus.validTri_R13H = 1'b0;
      n = 0; first = '0; last = '0;
      for (int k = 0; k < vecs[e].cycles + 3; k++) begin
        tick(acc);
        if (bus.validSamp_R14H != 0) begin
          if (n == 0) first = bus.validSamp_R14H;
          last = bus.validSamp_R14H;
          n++;
        end
      end
      chk("vec_cycles", n, vecs[e].cycles);
      chk("vec_first_mask", first, vecs[e].first);
      chk("vec_last_mask", last, vecs[e].last);
    end

    // Full 4x2 box, explicit values
    present(0, 0, 3072, 1024, 1024);
    bus.validTri_R13H = 1'b1;
    tick(acc);
    bus.validTri_R13H = 1'b0;
    #1;
    chk("s2_halt13_test", bus.halt_R13H, 1);
    tick(acc);
    chk("s2_c1_x", bus.sample_R14S[0], {24'd3072, 24'd2048, 24'd1024, 24'd0});
    chk("s2_c1_y", bus.sample_R14S[1][0], 0);
    chk("s2_c1_v", bus.validSamp_R14H, 4'b1111);
`ifdef ITER_BACK2BACK_EN
    chk("s2_halt13_last", bus.halt_R13H, 0);
`else
    chk("s2_halt13_last", bus.halt_R13H, 1);
`endif
    tick(acc);
    chk("s2_c2_x", bus.sample_R14S[0], {24'd3072, 24'd2048, 24'd1024, 24'd0});
    chk("s2_c2_y", bus.sample_R14S[1][3], 1024);
    chk("s2_c2_v", bus.validSamp_R14H, 4'b1111);
    tick(acc);
    chk("s2_done_v", bus.validSamp_R14H, 0);

    // Partial row
    present(0, 0, 1024, 0, 1024);
    bus.validTri_R13H = 1'b1;
    tick(acc);
    bus.validTri_R13H = 1'b0;
    tick(acc);
    chk("s3_v", bus.validSamp_R14H, 4'b0011);
    chk("s3_x1", bus.sample_R14S[0][1], 1024);
    tick(acc);

    // Downstream stall after first chunk
    present(0, 0, 3072, 1024, 1024);
    bus.validTri_R13H = 1'b1;
    tick(acc);
    bus.validTri_R13H = 1'b0;
    tick(acc);
    bus.halt_R14H = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(acc);
      chk("s4_frozen_y", bus.sample_R14S[1][0], 0);
      chk("s4_frozen_v", bus.validSamp_R14H, 4'b1111);
    end
    bus.halt_R14H = 1'b0;
    tick(acc);
    chk("s4_c2_y", bus.sample_R14S[1][0], 1024);
    tick(acc);
    chk("s4_done_v", bus.validSamp_R14H, 0);

    // Reset during first TEST cycle
    present(0, 0, 3072, 1024, 1024);
    bus.validTri_R13H = 1'b1;
    tick(acc);
    bus.validTri_R13H = 1'b0;
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    #1;
    chk("s5_v", bus.validSamp_R14H, 0);
    chk("s5_halt13", bus.halt_R13H, 0);
    for (int k = 0; k < 3; k++) begin
      tick(acc);
      chk("s5_quiet", bus.validSamp_R14H, 0);
    end

    // Back-to-back single-chunk boxes
    present(0, 0, 0, 0, 1024);
    bus.validTri_R13H = 1'b1;
    tick(acc);
    present(1024, 0, 1024, 0, 1024);
    pat = '0;
    for (int k = 0; k < 4; k++) begin
      tick(acc);
      if (acc) bus.validTri_R13H = 1'b0;
      pat[k] = |bus.validSamp_R14H;
    end
    bus.validTri_R13H = 1'b0;
`ifdef ITER_BACK2BACK_EN
    chk("s6_pattern", pat, 4'b0011);
`else
    chk("s6_pattern", pat, 4'b0101);
`endif
    tick(acc); tick(acc);

    // Randomized traffic with stalls and occasional reset
    pend = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        int st, llx, lly;
        st  = 512 << $urandom_range(0, 2);
        llx = (int'($urandom_range(0, 16)) - 8) * st;
        lly = (int'($urandom_range(0, 16)) - 8) * st;
        present(llx, lly, llx + int'($urandom_range(0, 9)) * st, lly + int'($urandom_range(0, 3)) * st, st);
        pend = 1'b1;
      end
      bus.validTri_R13H = pend;
      bus.halt_R14H = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick(acc);
      if (acc) pend = 1'b0;
    end
    rst = 1'b0;
    bus.validTri_R13H = 1'b0;
    bus.halt_R14H = 1'b0;
    for (int k = 0; k < 40; k++) tick(acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
